// File: rtl/barrett_mu_gen.sv
// ---------------------------------------------------------------------------
// barrett_mu_gen
//
// Computes the Barrett reduction constant mu = floor(2^64 / q) for a 64-bit
// unsigned modulus q, using a bit-serial restoring divider. The divider
// produces one quotient bit per cycle, MSB first.
//
// Handshake: a request is accepted on a rising edge where the block is IDLE
// and start=1; q is captured on that same edge. busy rises from the accepting
// edge and stays high until the block returns to IDLE. start is ignored
// whenever busy=1. done is a single-cycle pulse that marks mu/err as freshly
// updated. There is no back-pressure: the result must be taken while done=1,
// and it remains readable on mu/err until the next completion.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   start      request strobe, only looked at in IDLE
//   q          64-bit modulus, captured on the accepting edge
//   busy       high in CALC and DONE
//   done       high for the single DONE cycle
//   mu         floor(2^64 / q); all ones when q < 2
//   err        set with done when q < 2
//   dbg_state  current FSM state (0 IDLE, 1 CALC, 2 DONE)
// ---------------------------------------------------------------------------
module barrett_mu_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] q,
    output logic        busy,
    output logic        done,
    output logic [63:0] mu,
    output logic        err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [63:0] q_reg;
    logic [63:0] quo;
    logic [64:0] rem;
    logic [5:0]  cnt;

    logic        q_small;
    logic [64:0] rem_sh;
    logic [64:0] rem_sub;
    logic        q_bit;

    // One restoring-division step. rem is always < q_reg < 2^64, so the
    // shifted value fits in 65 bits without loss.
    always_comb begin
        rem_sh  = rem << 1;
        q_bit   = (rem_sh >= {1'b0, q_reg});
        rem_sub = rem_sh - {1'b0, q_reg};
        q_small = (q_reg[63:1] == 63'd0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic. A degenerate modulus (q < 2) still spends one cycle
    // in CALC so that DONE is entered on the edge after acceptance; CALC
    // short-circuits straight to DONE in that case.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_CALC;
                end
            end
            S_CALC: begin
                if (q_small || (cnt == 6'd0)) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Datapath. The dividend 2^64 is represented by starting the remainder
    // at 1; the 64 shift steps then bring in the 64 zero bits below it.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= 64'd0;
            quo   <= 64'd0;
            rem   <= 65'd0;
            cnt   <= 6'd0;
            mu    <= 64'd0;
            err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        q_reg <= q;
                        rem   <= 65'd1;
                        cnt   <= 6'd63;
                        quo   <= 64'd0;
                    end
                end
                S_CALC: begin
                    if (q_small) begin
                        mu  <= {64{1'b1}};
                        err <= 1'b1;
                    end else begin
                        rem <= q_bit ? rem_sub : rem_sh;
                        quo <= {quo[62:0], q_bit};
                        cnt <= cnt - 6'd1;
                        if (cnt == 6'd0) begin
                            mu  <= {quo[62:0], q_bit};
                            err <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        dbg_state = state;
    end

endmodule

// File: tb/tb_barrett_mu_gen.sv
// ---------------------------------------------------------------------------
// tb_barrett_mu_gen
//
// Directed and randomised checks of barrett_mu_gen. Inputs are driven and
// outputs sampled on the falling clock edge. Expected {err, mu} pairs are
// queued when a request is launched and popped when done is seen.
// ---------------------------------------------------------------------------
module tb_barrett_mu_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] q;
    logic        busy;
    logic        done;
    logic [63:0] mu;
    logic        err;
    logic [1:0]  dbg_state;

    int check_cnt = 0;
    int pass_cnt  = 0;

    logic [64:0] exp_q[$];

    barrett_mu_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .mu        (mu),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] expv);
        check_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    // Reference {err, mu}, computed by wide division of 2^64.
    function automatic logic [64:0] ref_result(input logic [63:0] qv);
        logic [64:0] two64;
        logic [64:0] quo;
        two64 = {1'b1, 64'd0};
        if (qv < 64'd2) begin
            return {1'b1, {64{1'b1}}};
        end
        quo = two64 / {1'b0, qv};
        return {1'b0, quo[63:0]};
    endfunction

    // Drive one start pulse; returns at the falling edge right after the
    // accepting edge. q is scrambled immediately afterwards.
    task automatic launch(input logic [63:0] qv, input logic [64:0] expv);
        @(negedge clk);
        start = 1'b1;
        q     = qv;
        exp_q.push_back(expv);
        @(negedge clk);
        start = 1'b0;
        q     = {$urandom, $urandom};
    endtask

    // Wait (bounded) for done, check latency, busy length, result, and
    // the return to IDLE. With poke set, start and q are hammered during
    // the whole run, including the DONE cycle.
    task automatic wait_done(input int exp_lat, input bit poke);
        int          n;
        int          busy_n;
        logic [64:0] expv;
        n      = 0;
        busy_n = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && n < 200) begin
            if (poke) begin
                start = 1'b1;
                q     = {$urandom, $urandom};
            end
            @(negedge clk);
            n++;
            if (busy === 1'b1) busy_n++;
        end
        check("latency", 65'(n), 65'(exp_lat));
        check("busy_len", 65'(busy_n), 65'(exp_lat + 1));
        expv = (exp_q.size() != 0) ? exp_q.pop_front() : 65'd0;
        check("mu", {1'b0, mu}, {1'b0, expv[63:0]});
        check("err", {64'd0, err}, {64'd0, expv[64]});
        @(negedge clk);
        check("done_pulse", {64'd0, done}, 65'd0);
        check("busy_clear", {64'd0, busy}, 65'd0);
        start = 1'b0;
        @(negedge clk);
        check("no_restart", {64'd0, busy}, 65'd0);
    endtask

    initial begin
        logic [63:0]  qv;
        logic [128:0] lo;
        logic [128:0] hi;
        logic [128:0] two64w;
        bit           saw_done;

        // Reset, with start held high to show reset wins.
        rst   = 1'b1;
        start = 1'b1;
        q     = 64'd3;
        repeat (3) @(negedge clk);
        check("rst_busy", {64'd0, busy}, 65'd0);
        check("rst_done", {64'd0, done}, 65'd0);
        check("rst_mu", {1'b0, mu}, 65'd0);
        check("rst_err", {64'd0, err}, 65'd0);
        check("rst_state", {63'd0, dbg_state}, 65'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {64'd0, busy}, 65'd0);

        // Basic result
        launch(64'd3, {1'b0, 64'h5555_5555_5555_5555});
        wait_done(64, 1'b0);

        // Boundary values
        launch(64'd2, {1'b0, 64'h8000_0000_0000_0000});
        wait_done(64, 1'b0);
        launch(64'hFFFF_FFFF_0000_0001, {1'b0, 64'd1});
        wait_done(64, 1'b0);
        launch(64'hFFFF_FFFF_FFFF_FFFF, {1'b0, 64'd1});
        wait_done(64, 1'b0);
        launch(64'd7, {1'b0, 64'h2492_4924_9249_2492});
        wait_done(64, 1'b0);

        // Error path, then a valid q clears err
        launch(64'd0, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        wait_done(1, 1'b0);
        launch(64'd1, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        wait_done(1, 1'b0);
        launch(64'd5, {1'b0, 64'h3333_3333_3333_3333});
        wait_done(64, 1'b0);

        // start/q activity during CALC and DONE must be ignored
        launch(64'd9, {1'b0, 64'h1C71_C71C_71C7_1C71});
        wait_done(64, 1'b1);
        launch(64'd1, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        wait_done(1, 1'b1);

        // Reset in the middle of CALC
        @(negedge clk);
        start = 1'b1;
        q     = 64'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        check("mid_busy", {64'd0, busy}, 65'd1);
        check("mid_state", {63'd0, dbg_state}, 65'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {64'd0, busy}, 65'd0);
        check("abort_mu", {1'b0, mu}, 65'd0);
        check("abort_err", {64'd0, err}, 65'd0);
        saw_done = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", {64'd0, saw_done}, 65'd0);
        launch(64'd3, {1'b0, 64'h5555_5555_5555_5555});
        wait_done(64, 1'b0);

        // Randomised against the reference model, plus the Barrett bound
        two64w = 129'd1 << 64;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                qv = 64'($urandom_range(2, 1000));
            end else begin
                qv = {$urandom, $urandom};
            end
            if (qv < 64'd2) qv = 64'd2;
            launch(qv, ref_result(qv));
            wait_done(64, 1'b0);
            lo = 129'(mu) * 129'(qv);
            hi = lo + 129'(qv);
            check("bound", {64'd0, (lo <= two64w) && (hi > two64w)}, 65'd1);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
